imm_inst_encoder: RTL
=====================

# imm_inst_encoder

Packs a 32-bit immediate and register/opcode fields into RISC-V RV32I instruction words, the inverse of the immediate extender. Sits between the test/boot instruction generator and the instruction memory write port. Also expands the load-immediate pseudo-op into a LUI/ADDI pair. Uses a valid/ready handshake on both sides with a registered output.

## Interface
Parameters:
- `XLEN`, 32, data and instruction width; only 32 is supported.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when both valid and ready are high.
- `req_kind`  in  3  format select: 0 I, 1 S, 2 B, 3 U, 4 J, 5 LI (pseudo); 6 and 7 are reserved.
- `req_opcode`  in  7  opcode for kinds 0–4; ignored for LI.
- `req_funct3`  in  3  funct3 for I, S and B; ignored otherwise.
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register fields.
- `req_imm`  in  32  signed immediate, byte offset for B and J.
- `inst_valid`  out  1  instruction word present.
- `inst_ready`  in  1  downstream accepts the word.
- `inst_word`  out  32  encoded instruction.
- `inst_last`  out  1  final word of the request.
- `inst_err`  out  1  immediate out of range, or reserved kind.

## Operation
- FSM states: IDLE, EMIT1, EMIT2. `req_ready` is high only in IDLE.
- **IDLE → EMIT1** on accept. `inst_word` is loaded with the first word.
- **EMIT1 → IDLE** on output accept when `inst_last` is 1. **EMIT1 → EMIT2** when `inst_last` is 0.
- **EMIT2 → IDLE** on output accept.
- Field packing for kinds 0–4:
  - I: imm[11:0] goes to [31:20].
  - S: imm[11:5] goes to [31:25] and imm[4:0] to [11:7].
  - B: [31] ← imm[12], [30:25] ← imm[10:5], [11:8] ← imm[4:1], [7] ← imm[11].
  - U: imm[31:12] goes to [31:12].
  - J: [31] ← imm[20], [30:21] ← imm[10:1], [20] ← imm[11], [19:12] ← imm[19:12].
  - Fields a format does not use are zero. Opcode goes to [6:0].
- LI expansion:
  - lo = sign-extended imm[11:0]; hi = (imm + 0x800) >> 12, truncated to 20 bits.
  - hi == 0: emit one word, ADDI rd, x0, lo.
  - lo == 0: emit one word, LUI rd, hi.
  - Otherwise emit two words: LUI rd, hi, then ADDI rd, rd, lo.
  - Opcodes are fixed: LUI 0x37, ADDI 0x13 with funct3 0.
- `inst_last` is 1 on single-word results and on the second LI word.
- Reserved kind: `inst_word` = 0, `inst_err` = 1, one word emitted.

## Timing
- Reset values: `inst_valid`=0, `inst_word`=0, `inst_last`=0, `inst_err`=0, state IDLE, `req_ready`=1.
- Latency: a request accepted at edge N gives `inst_valid`=1 after edge N. The second LI word is valid in the cycle after the first is accepted.
- Throughput: at most one request every 2 cycles for single-word results, every 3 cycles for LI pairs.
- While `inst_valid` && !`inst_ready`, the words `inst_word`, `inst_last` and `inst_err` hold stable.
- `req_*` is sampled only on the accept edge. Later changes have no effect.
- `rst_n` low at any edge, including mid-pair in EMIT2, forces the reset values at that edge. No partial pair resumes.

## Configuration
- Macro: `IMM_RANGE_CHECK_EN`.
- Defined: `inst_err` is set on any word of a request whose immediate is out of range. Ranges:
  - I/S: signed 12-bit.
  - B: signed 13-bit with imm[0]=0.
  - J: signed 21-bit with imm[0]=0.
  - U: imm[11:0]=0.
  - Fields are still packed truncated.
- Not defined: `inst_err` is set only for reserved kinds. No range logic is synthesised.

## Test plan
- I kind, opcode 0x13, funct3 0, rd=1, rs1=0, imm=0xFFFFFFFC → single word 0xFFC00093, `inst_last`=1, `inst_err`=0.
- B kind, opcode 0x63, funct3 0, rs1=1, rs2=2, imm=8 → 0x00208463.
- LI, rd=5, imm=0x12345FFF → 0x123462B7 (`inst_last`=0), then 0xFFF28293 (`inst_last`=1). Hold `inst_ready` low for 3 cycles on the first word; the word must stay stable and `req_ready`=0 throughout.
- LI, rd=5, imm=0x7FF → single word 0x7FF00293. LI, rd=5, imm=0x1000 → single word 0x000012B7.
- I kind, imm=2048 → word 0x80000093 (rd=1). `inst_err`=1 with `IMM_RANGE_CHECK_EN` defined, 0 without it. Also drive kind 6 → word 0, `inst_err`=1.
- Drive `rst_n` low in EMIT2 of an LI pair → next edge gives `inst_valid`=0 and `req_ready`=1. A new request then encodes correctly.

Source files
------------

// File: rtl/imm_inst_encoder.sv
// RV32I instruction packer: immediate + fields -> instruction word, LI -> LUI/ADDI.
// Optional IMM_RANGE_CHECK_EN flags immediates that do not fit their format.
module imm_inst_encoder #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_kind,
  input  logic [6:0]      req_opcode,
  input  logic [2:0]      req_funct3,
  input  logic [4:0]      req_rd,
  input  logic [4:0]      req_rs1,
  input  logic [4:0]      req_rs2,
  input  logic [XLEN-1:0] req_imm,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_word,
  output logic            inst_last,
  output logic            inst_err
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT1,
    EMIT2
  } state_t;

  localparam logic [6:0] OP_LUI  = 7'h37;
  localparam logic [6:0] OP_ADDI = 7'h13;

  state_t          state_q, state_d;
  logic [XLEN-1:0] word_q, word_d;
  logic [XLEN-1:0] word2_q, word2_d;
  logic            last_q, last_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] enc_w1, enc_w2;
  logic            enc_two, enc_err;

  logic k_i, k_s, k_b, k_u, k_j, k_li;

  assign k_i  = req_kind == 3'd0;
  assign k_s  = req_kind == 3'd1;
  assign k_b  = req_kind == 3'd2;
  assign k_u  = req_kind == 3'd3;
  assign k_j  = req_kind == 3'd4;
  assign k_li = req_kind == 3'd5;

  // hi rounds up when lo is negative so that hi<<12 + sext(lo) == imm
  logic [19:0]     li_hi;
  logic [XLEN-1:0] li_lui, li_addi0, li_addi;

  assign li_hi    = req_imm[31:12] + {19'd0, req_imm[11]};
  assign li_lui   = {li_hi, req_rd, OP_LUI};
  assign li_addi0 = {req_imm[11:0], 5'd0, 3'd0, req_rd, OP_ADDI};
  assign li_addi  = {req_imm[11:0], req_rd, 3'd0, req_rd, OP_ADDI};

  logic bad_12, bad_b, bad_j, bad_u;

`ifdef IMM_RANGE_CHECK_EN
  assign bad_12 = !(&req_imm[31:11] || ~|req_imm[31:11]);
  assign bad_b  = !(&req_imm[31:12] || ~|req_imm[31:12])
                  || req_imm[0];
  assign bad_j  = !(&req_imm[31:20] || ~|req_imm[31:20])
                  || req_imm[0];
  assign bad_u  = |req_imm[11:0];
`else
  assign bad_12 = 1'b0;
  assign bad_b  = 1'b0;
  assign bad_j  = 1'b0;
  assign bad_u  = 1'b0;
`endif

  always_comb begin
    enc_w1  = '0;
    enc_w2  = '0;
    enc_two = 1'b0;
    enc_err = 1'b0;
    unique case (1'b1)
      k_i: begin
        enc_w1  = {req_imm[11:0], req_rs1, req_funct3,
                   req_rd, req_opcode};
        enc_err = bad_12;
      end
      k_s: begin
        enc_w1  = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                   req_imm[4:0], req_opcode};
        enc_err = bad_12;
      end
      k_b: begin
        enc_w1  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1,
                   req_funct3, req_imm[4:1], req_imm[11],
                   req_opcode};
        enc_err = bad_b;
      end
      k_u: begin
        enc_w1  = {req_imm[31:12], req_rd, req_opcode};
        enc_err = bad_u;
      end
      k_j: begin
        enc_w1  = {req_imm[20], req_imm[10:1], req_imm[11],
                   req_imm[19:12], req_rd, req_opcode};
        enc_err = bad_j;
      end
      k_li: begin
        if (li_hi == 20'd0) begin
          enc_w1 = li_addi0;
        end else if (req_imm[11:0] == 12'd0) begin
          enc_w1 = li_lui;
        end else begin
          enc_w1  = li_lui;
          enc_w2  = li_addi;
          enc_two = 1'b1;
        end
      end
      default: begin
        enc_w1  = '0;
        enc_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    word2_d = word2_q;
    last_d  = last_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = EMIT1;
          word_d  = enc_w1;
          word2_d = enc_w2;
          last_d  = !enc_two;
          err_d   = enc_err;
        end
      end
      EMIT1: begin
        if (inst_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            state_d = EMIT2;
            word_d  = word2_q;
            last_d  = 1'b1;
          end
        end
      end
      EMIT2: begin
        if (inst_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      word2_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      word2_q <= word2_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = state_q == IDLE;
  assign inst_valid = state_q != IDLE;
  assign inst_word  = word_q;
  assign inst_last  = last_q;
  assign inst_err   = err_q;

endmodule
